// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin choice among input requesters,
// grant locked until the tail flit crosses, plus optional stall watchdog.
module output_port_arbiter #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_PORTS-1:0] req_i,
  input  logic               xfer_i,
  input  logic               tail_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               arb_o,
  output logic [N_PORTS-1:0] filter_o,
  output logic               err_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_PORTS - 1);

  generate
    if (N_PORTS < 2 || (1 << SEL_W) < N_PORTS) begin : g_param_check
      $error("output_port_arbiter: SEL_W too narrow for N_PORTS");
    end
  endgenerate

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   win;
  logic               found;
  logic               release_lock;
  logic [SEL_W-1:0]   ptr_next;
  logic [N_PORTS-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic               arb_q;
  logic               err_q;
  logic [CNT_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]   wd_inc;

  assign release_lock = (state == LOCKED) && xfer_i && tail_i;
  assign ptr_next     = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
  assign wd_inc       = wd_cnt + 1'b1;

  // Round-robin scan starting at ptr, wrapping past the last input.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    state_next = state;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && req_i[(int'(ptr) + i) % N_PORTS]) begin
        found = 1'b1;
        win   = SEL_W'((int'(ptr) + i) % N_PORTS);
      end
    end
    case (state)
      IDLE:    if (found) state_next = LOCKED;
      LOCKED:  if (release_lock) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      arb_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= N_PORTS'(1) << win;
            sel_q   <= win;
            arb_q   <= 1'b1;
            wd_cnt  <= '0;
          end
        end
        LOCKED: begin
          if (release_lock) begin
            grant_q <= '0;
            arb_q   <= 1'b0;
            ptr     <= ptr_next;
          end
          // With TIMEOUT=0 the count sits at TO_VAL and never advances.
          if (xfer_i) begin
            wd_cnt <= '0;
          end else if (wd_cnt != TO_VAL) begin
            wd_cnt <= wd_inc;
            if (wd_inc == TO_VAL) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o  = grant_q;
  assign sel_o    = sel_q;
  assign arb_o    = arb_q;
  assign err_o    = err_q;
  assign filter_o = req_i & ~grant_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: grant order, lock hold, single-flit
// packets, async reset mid-packet and the watchdog with TIMEOUT=4.
module tb_output_port_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] req_i;
  logic       xfer_i;
  logic       tail_i;
  logic [4:0] grant_o;
  logic [2:0] sel_o;
  logic       arb_o;
  logic [4:0] filter_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  output_port_arbiter #(.N_PORTS(5), .SEL_W(3), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .xfer_i(xfer_i),
    .tail_i(tail_i), .grant_o(grant_o), .sel_o(sel_o), .arb_o(arb_o),
    .filter_o(filter_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] req, input logic xfer,
                               input logic tail);
    req_i  = req;
    xfer_i = xfer;
    tail_i = tail;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(5'b0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
  endtask

  logic [4:0] rr_order [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

  initial begin
    // Reset state and basic grant/release
    doReset();
    checkOutput("rst_grant", grant_o, 5'b0);
    checkOutput("rst_sel", sel_o, 3'd0);
    checkOutput("rst_arb", arb_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    applyStimulus(5'b00100, 1'b0, 1'b0);
    #1 checkOutput("idle_filter", filter_o, 5'b00100);
    tick();
    checkOutput("g2_grant", grant_o, 5'b00100);
    checkOutput("g2_sel", sel_o, 3'd2);
    checkOutput("g2_arb", arb_o, 1'b1);
    checkOutput("g2_filter", filter_o, 5'b0);
    applyStimulus(5'b00100, 1'b1, 1'b1);
    tick();
    checkOutput("g2_rel_grant", grant_o, 5'b0);
    checkOutput("g2_rel_arb", arb_o, 1'b0);
    // ptr=3 means 5'b10100 picks input 4, not input 2
    applyStimulus(5'b10100, 1'b0, 1'b0);
    tick();
    checkOutput("ptr3_grant", grant_o, 5'b10000);
    checkOutput("ptr3_sel", sel_o, 3'd4);
    applyStimulus(5'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'b0, 1'b0, 1'b0);

    // Round robin over five 3-flit packets
    doReset();
    applyStimulus(5'b11111, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr%0d_grant", k), grant_o, rr_order[k]);
      checkOutput($sformatf("rr%0d_sel", k), sel_o, k);
      for (int f = 1; f <= 3; f++) begin
        applyStimulus(5'b11111, 1'b1, f == 3);
        tick();
        if (f < 3) checkOutput($sformatf("rr%0d_hold%0d", k, f), grant_o, rr_order[k]);
      end
      checkOutput($sformatf("rr%0d_bubble", k), grant_o, 5'b0);
      checkOutput($sformatf("rr%0d_bubble_arb", k), arb_o, 1'b0);
      applyStimulus(5'b11111, 1'b0, 1'b0);
      tick();
    end
    // After input 4 the pointer wrapped to 0, so the next grant is input 0
    checkOutput("rr_wrap", grant_o, 5'b00001);
    applyStimulus(5'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'b0, 1'b0, 1'b0);

    // Lock hold: ptr=1, input 1 wins, then drops req while 3 asks
    applyStimulus(5'b00010, 1'b0, 1'b0);
    tick();
    checkOutput("lk_grant", grant_o, 5'b00010);
    applyStimulus(5'b00010, 1'b1, 1'b0);
    tick();
    applyStimulus(5'b01000, 1'b0, 1'b0);
    #1 checkOutput("lk_filter", filter_o, 5'b01000);
    checkOutput("lk_hold1", grant_o, 5'b00010);
    tick();
    checkOutput("lk_hold2", grant_o, 5'b00010);
    applyStimulus(5'b01000, 1'b1, 1'b1);
    tick();
    checkOutput("lk_bubble", grant_o, 5'b0);
    checkOutput("lk_bubble_filter", filter_o, 5'b01000);
    applyStimulus(5'b01000, 1'b0, 1'b0);
    tick();
    checkOutput("lk_next_grant", grant_o, 5'b01000);
    checkOutput("lk_next_sel", sel_o, 3'd3);
    applyStimulus(5'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'b0, 1'b0, 1'b0);

    // Single-flit packets alternate 0,4,0; tail without xfer is ignored
    doReset();
    applyStimulus(5'b10001, 1'b0, 1'b0);
    tick();
    checkOutput("sf_g0", grant_o, 5'b00001);
    applyStimulus(5'b10001, 1'b1, 1'b1);
    tick();
    checkOutput("sf_b0", grant_o, 5'b0);
    applyStimulus(5'b10001, 1'b0, 1'b0);
    tick();
    checkOutput("sf_g4", grant_o, 5'b10000);
    applyStimulus(5'b10001, 1'b1, 1'b1);
    tick();
    checkOutput("sf_b4", grant_o, 5'b0);
    applyStimulus(5'b10001, 1'b0, 1'b0);
    tick();
    checkOutput("sf_g0b", grant_o, 5'b00001);
    applyStimulus(5'b10001, 1'b0, 1'b1);
    tick();
    checkOutput("sf_tail_noxfer1", grant_o, 5'b00001);
    tick();
    checkOutput("sf_tail_noxfer2", arb_o, 1'b1);
    applyStimulus(5'b0, 1'b1, 1'b1);
    tick();
    checkOutput("sf_final_rel", grant_o, 5'b0);
    applyStimulus(5'b0, 1'b0, 1'b0);

    // Async reset mid-packet (ptr=1 so input 3 wins)
    applyStimulus(5'b01000, 1'b0, 1'b0);
    tick();
    checkOutput("mr_grant", grant_o, 5'b01000);
    applyStimulus(5'b01000, 1'b1, 1'b0);
    tick();
    #2 rst_i = 1'b1;
    #1;
    checkOutput("mr_grant0", grant_o, 5'b0);
    checkOutput("mr_sel0", sel_o, 3'd0);
    checkOutput("mr_arb0", arb_o, 1'b0);
    applyStimulus(5'b01001, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();
    checkOutput("mr_after_grant", grant_o, 5'b00001);
    checkOutput("mr_after_sel", sel_o, 3'd0);
    applyStimulus(5'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'b0, 1'b0, 1'b0);

    // Watchdog: 4 locked cycles with no transfer sets err
    doReset();
    applyStimulus(5'b00100, 1'b0, 1'b0);
    tick();
    checkOutput("wd_grant", grant_o, 5'b00100);
    checkOutput("wd_err_c0", err_o, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput($sformatf("wd_err_c%0d", c), err_o, 1'b0);
    end
    tick();
    checkOutput("wd_err_c4", err_o, 1'b1);
    checkOutput("wd_lock_kept", grant_o, 5'b00100);
    applyStimulus(5'b0, 1'b1, 1'b0);
    tick();
    checkOutput("wd_sticky_xfer", err_o, 1'b1);
    applyStimulus(5'b0, 1'b1, 1'b1);
    tick();
    checkOutput("wd_rel_grant", grant_o, 5'b0);
    checkOutput("wd_sticky_rel", err_o, 1'b1);
    doReset();
    checkOutput("wd_err_cleared", err_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
